// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the CPU-side memory bus controller.
// Region decode is on cpu_address[26:24]; local address widths follow each target port.
package mem_bus_pkg;

   localparam int unsigned ADDR_W   = 27;
   localparam int unsigned DATA_W   = 32;
   localparam int unsigned SDRAM_AW = 26;
   localparam int unsigned VRAM_AW  = 14;
   localparam int unsigned ROM_AW   = 10;
   localparam int unsigned IO_AW    = 8;
   localparam int unsigned CNT_W    = 10;

   localparam logic [2:0] DEC_VRAM     = 3'b100;
   localparam logic [2:0] DEC_ROM      = 3'b101;
   localparam logic [2:0] DEC_IO       = 3'b110;
   localparam logic [2:0] DEC_UNMAPPED = 3'b111;

   typedef enum logic [2:0] {
      REG_SDRAM,
      REG_VRAM,
      REG_ROM,
      REG_IO,
      REG_UNMAPPED
   } region_e;

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StFixedWait,
      StSdramWait,
      StDone
   } state_e;

endpackage

// File: rtl/mem_bus_decode.sv
// Combinational address decode: CPU word address to target region and local addresses.
module mem_bus_decode
   import mem_bus_pkg::*;
(
   input  logic [ADDR_W-1:0]   addr,
   output region_e             region,
   output logic [SDRAM_AW-1:0] sdram_addr,
   output logic [VRAM_AW-1:0]  vram_addr,
   output logic [ROM_AW-1:0]   rom_addr,
   output logic [IO_AW-1:0]    io_addr
);

   always_comb begin
      region = REG_UNMAPPED;
      if (!addr[26]) begin
         region = REG_SDRAM;
      end else begin
         case (addr[26:24])
            DEC_VRAM:     region = REG_VRAM;
            DEC_ROM:      region = REG_ROM;
            DEC_IO:       region = REG_IO;
            DEC_UNMAPPED: region = REG_UNMAPPED;
            default:      region = REG_UNMAPPED;
         endcase
      end
   end

   assign sdram_addr = addr[SDRAM_AW-1:0];
   assign vram_addr  = addr[VRAM_AW-1:0];
   assign rom_addr   = addr[ROM_AW-1:0];
   assign io_addr    = addr[IO_AW-1:0];

endmodule

// File: rtl/mem_bus_ctrl.sv
// Single-outstanding memory bus controller between the CPU bus and SDRAM/VRAM/ROM/IO targets.
// Target outputs are registered at the start edge so they are valid throughout ISSUE.
module mem_bus_ctrl
   import mem_bus_pkg::*;
#(
   parameter int unsigned FIXED_LAT     = 1,
   parameter int unsigned SDRAM_TIMEOUT = 255,
   parameter logic [31:0] ERR_WORD      = 32'hDEAD_BEEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [ADDR_W-1:0]   cpu_address,
   input  logic [DATA_W-1:0]   cpu_data,
   input  logic                cpu_we,
   input  logic                cpu_start,
   output logic [DATA_W-1:0]   cpu_q,
   output logic                cpu_busy,
   output logic [SDRAM_AW-1:0] sdram_addr,
   output logic [DATA_W-1:0]   sdram_d,
   output logic                sdram_we,
   output logic                sdram_req,
   input  logic                sdram_ack,
   input  logic [DATA_W-1:0]   sdram_q,
   output logic [VRAM_AW-1:0]  vram_addr,
   output logic [DATA_W-1:0]   vram_d,
   output logic                vram_we,
   input  logic [DATA_W-1:0]   vram_q,
   output logic [ROM_AW-1:0]   rom_addr,
   input  logic [DATA_W-1:0]   rom_q,
   output logic [IO_AW-1:0]    io_addr,
   output logic [DATA_W-1:0]   io_d,
   output logic                io_we,
   output logic                io_re,
   input  logic [DATA_W-1:0]   io_q,
   output logic                bus_err
);

   state_e              state_q, state_d;
   region_e             region_q, region_d;
   logic                we_q, we_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                err_q, err_d;
   logic                sdram_req_q, sdram_req_d;
   logic                sdram_we_q, sdram_we_d;
   logic [SDRAM_AW-1:0] sdram_addr_q, sdram_addr_d;
   logic [DATA_W-1:0]   sdram_d_q, sdram_d_d;
   logic [VRAM_AW-1:0]  vram_addr_q, vram_addr_d;
   logic [DATA_W-1:0]   vram_d_q, vram_d_d;
   logic                vram_we_q, vram_we_d;
   logic [ROM_AW-1:0]   rom_addr_q, rom_addr_d;
   logic [IO_AW-1:0]    io_addr_q, io_addr_d;
   logic [DATA_W-1:0]   io_d_q, io_d_d;
   logic                io_we_q, io_we_d;
   logic                io_re_q, io_re_d;

   region_e             dec_region;
   logic [SDRAM_AW-1:0] dec_sdram_addr;
   logic [VRAM_AW-1:0]  dec_vram_addr;
   logic [ROM_AW-1:0]   dec_rom_addr;
   logic [IO_AW-1:0]    dec_io_addr;

   mem_bus_decode u_decode (
      .addr       (cpu_address),
      .region     (dec_region),
      .sdram_addr (dec_sdram_addr),
      .vram_addr  (dec_vram_addr),
      .rom_addr   (dec_rom_addr),
      .io_addr    (dec_io_addr)
   );

   always_comb begin
      state_d      = state_q;
      region_d     = region_q;
      we_d         = we_q;
      cnt_d        = cnt_q;
      rdata_d      = rdata_q;
      err_d        = err_q;
      sdram_req_d  = sdram_req_q;
      sdram_we_d   = sdram_we_q;
      sdram_addr_d = sdram_addr_q;
      sdram_d_d    = sdram_d_q;
      vram_addr_d  = vram_addr_q;
      vram_d_d     = vram_d_q;
      rom_addr_d   = rom_addr_q;
      io_addr_d    = io_addr_q;
      io_d_d       = io_d_q;
      vram_we_d    = 1'b0;
      io_we_d      = 1'b0;
      io_re_d      = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (cpu_start) begin
               state_d  = StIssue;
               region_d = dec_region;
               we_d     = cpu_we;
               // Strobes set here are high for exactly the ISSUE cycle.
               case (dec_region)
                  REG_SDRAM: begin
                     sdram_addr_d = dec_sdram_addr;
                     sdram_d_d    = cpu_data;
                     sdram_we_d   = cpu_we;
                     sdram_req_d  = 1'b1;
                  end
                  REG_VRAM: begin
                     vram_addr_d = dec_vram_addr;
                     vram_d_d    = cpu_data;
                     vram_we_d   = cpu_we;
                  end
                  REG_ROM: rom_addr_d = dec_rom_addr;
                  REG_IO: begin
                     io_addr_d = dec_io_addr;
                     io_d_d    = cpu_data;
                     io_we_d   = cpu_we;
                     io_re_d   = ~cpu_we;
                  end
                  default: ;
               endcase
            end
         end
         StIssue: begin
            case (region_q)
               REG_SDRAM: begin
                  cnt_d   = CNT_W'(SDRAM_TIMEOUT);
                  state_d = StSdramWait;
               end
               REG_VRAM, REG_IO: begin
                  cnt_d   = CNT_W'(FIXED_LAT);
                  state_d = StFixedWait;
               end
               REG_ROM: begin
                  if (we_q) begin
                     state_d = StDone;
                  end else begin
                     cnt_d   = CNT_W'(FIXED_LAT);
                     state_d = StFixedWait;
                  end
               end
               default: begin
                  if (!we_q) rdata_d = '0;
                  state_d = StDone;
               end
            endcase
         end
         StFixedWait: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q <= CNT_W'(1)) begin
               state_d = StDone;
               if (!we_q) begin
                  case (region_q)
                     REG_VRAM: rdata_d = vram_q;
                     REG_ROM:  rdata_d = rom_q;
                     default:  rdata_d = io_q;
                  endcase
               end
            end
         end
         StSdramWait: begin
            // An ack in the expiry cycle takes priority over the timeout.
            if (sdram_ack) begin
               if (!we_q) rdata_d = sdram_q;
               sdram_req_d = 1'b0;
               sdram_we_d  = 1'b0;
               state_d     = StDone;
            end else if (cnt_q <= CNT_W'(1)) begin
               err_d = 1'b1;
               if (!we_q) rdata_d = ERR_WORD;
               sdram_req_d = 1'b0;
               sdram_we_d  = 1'b0;
               state_d     = StDone;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         region_q     <= REG_UNMAPPED;
         we_q         <= 1'b0;
         cnt_q        <= '0;
         rdata_q      <= '0;
         err_q        <= 1'b0;
         sdram_req_q  <= 1'b0;
         sdram_we_q   <= 1'b0;
         sdram_addr_q <= '0;
         sdram_d_q    <= '0;
         vram_addr_q  <= '0;
         vram_d_q     <= '0;
         vram_we_q    <= 1'b0;
         rom_addr_q   <= '0;
         io_addr_q    <= '0;
         io_d_q       <= '0;
         io_we_q      <= 1'b0;
         io_re_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         region_q     <= region_d;
         we_q         <= we_d;
         cnt_q        <= cnt_d;
         rdata_q      <= rdata_d;
         err_q        <= err_d;
         sdram_req_q  <= sdram_req_d;
         sdram_we_q   <= sdram_we_d;
         sdram_addr_q <= sdram_addr_d;
         sdram_d_q    <= sdram_d_d;
         vram_addr_q  <= vram_addr_d;
         vram_d_q     <= vram_d_d;
         vram_we_q    <= vram_we_d;
         rom_addr_q   <= rom_addr_d;
         io_addr_q    <= io_addr_d;
         io_d_q       <= io_d_d;
         io_we_q      <= io_we_d;
         io_re_q      <= io_re_d;
      end
   end

   assign cpu_busy   = (state_q != StIdle) | cpu_start;
   assign cpu_q      = rdata_q;
   assign bus_err    = err_q;
   assign sdram_req  = sdram_req_q;
   assign sdram_we   = sdram_we_q;
   assign sdram_addr = sdram_addr_q;
   assign sdram_d    = sdram_d_q;
   assign vram_addr  = vram_addr_q;
   assign vram_d     = vram_d_q;
   assign vram_we    = vram_we_q;
   assign rom_addr   = rom_addr_q;
   assign io_addr    = io_addr_q;
   assign io_d       = io_d_q;
   assign io_we      = io_we_q;
   assign io_re      = io_re_q;

endmodule
